// File: rtl/win_pkg.sv
// Shared definitions for the K x K sliding-window generator: default pixel
// width, pixel type and the counter-width helper.
package win_pkg;

    localparam int DEF_DATA_WIDTH = 16;

    typedef logic [DEF_DATA_WIDTH-1:0] pix_t;

    // Width of a counter that spans 0..n-1; never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/window_gen_kxk_line_buffer.sv
// One image-line delay: dout presents the pixel written DEPTH enabled cycles
// earlier, read combinationally from a circular buffer.
module line_buffer
    import win_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout
);

    localparam int            AW   = cnt_w(DEPTH);
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ptr <= '0;
        else if (en)
            ptr <= (ptr == LAST) ? '0 : ptr + 1'b1;
    end

    // Storage is never reset; the window row gate hides stale contents.
    always_ff @(posedge clk) begin
        if (en)
            mem[ptr] <= din;
    end

    assign dout = mem[ptr];

endmodule

// File: rtl/window_gen_kxk.sv
// K x K sliding-window generator over a raster pixel stream, with frame sync,
// end-of-frame flag and stride-gated window valid. Optional macro WIN_COORD_EN
// adds the top-left coordinate outputs o_win_row / o_win_col.
module window_gen_kxk
    import win_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int K          = 3,
    parameter int IMG_WIDTH  = 8,
    parameter int IMG_HEIGHT = 8,
    parameter int STRIDE     = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      i_valid,
    input  logic                      i_sof,
    input  logic [DATA_WIDTH-1:0]     i_data,
    output logic                      o_valid,
    output logic                      o_eof,
`ifdef WIN_COORD_EN
    output logic [$clog2(IMG_HEIGHT)-1:0] o_win_row,
    output logic [$clog2(IMG_WIDTH)-1:0]  o_win_col,
`endif
    output logic [DATA_WIDTH*K*K-1:0] o_data
);

    localparam int ROW_W = cnt_w(IMG_HEIGHT);
    localparam int COL_W = cnt_w(IMG_WIDTH);
    localparam int PH_W  = cnt_w(STRIDE);

    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_K    = ROW_W'(K - 1);
    localparam logic [COL_W-1:0] COL_K    = COL_W'(K - 1);
    localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(STRIDE - 1);
    localparam logic [PH_W-1:0]  PH_TGT   = PH_W'((STRIDE > 0) ? (K - 1) % STRIDE : 0);

    if (K < 2 || K > IMG_WIDTH || K > IMG_HEIGHT || STRIDE < 1) begin : g_bad_param
        $error("window_gen_kxk: illegal parameters K=%0d IMG_WIDTH=%0d IMG_HEIGHT=%0d STRIDE=%0d",
               K, IMG_WIDTH, IMG_HEIGHT, STRIDE);
    end

    logic [ROW_W-1:0] row, pos_r, nxt_r;
    logic [COL_W-1:0] col, pos_c, nxt_c;
    logic [PH_W-1:0]  rph, cph, cur_rph, cur_cph, nxt_rph, nxt_cph;
    logic             col_wrap, row_wrap, win_ok;

    logic [DATA_WIDTH-1:0] tap [K];
    logic [DATA_WIDTH-1:0] win_p1 [K][K];
    logic                  vld_p1, eof_p1;

    // tap[j] carries pixel (r-j, c) while (r, c) is being accepted.
    assign tap[0] = i_data;
    for (genvar j = 1; j < K; j++) begin : g_lines
        line_buffer #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (IMG_WIDTH)
        ) u_line (
            .clk  (clk),
            .rst_n(rst_n),
            .en   (i_valid),
            .din  (tap[j-1]),
            .dout (tap[j])
        );
    end

    // Stride phases hold r mod STRIDE and c mod STRIDE, so no divider is needed.
    always_comb begin
        pos_r    = i_sof ? '0 : row;
        pos_c    = i_sof ? '0 : col;
        cur_rph  = i_sof ? '0 : rph;
        cur_cph  = i_sof ? '0 : cph;
        col_wrap = (pos_c == COL_LAST);
        row_wrap = (pos_r == ROW_LAST);
        nxt_c    = col_wrap ? '0 : pos_c + 1'b1;
        nxt_cph  = (col_wrap || cur_cph == PH_LAST) ? '0 : cur_cph + 1'b1;
        nxt_r    = pos_r;
        nxt_rph  = cur_rph;
        if (col_wrap) begin
            nxt_r   = row_wrap ? '0 : pos_r + 1'b1;
            nxt_rph = (row_wrap || cur_rph == PH_LAST) ? '0 : cur_rph + 1'b1;
        end
        win_ok = (pos_r >= ROW_K) && (pos_c >= COL_K) &&
                 (cur_rph == PH_TGT) && (cur_cph == PH_TGT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row <= '0;
            col <= '0;
            rph <= '0;
            cph <= '0;
        end else if (i_valid) begin
            row <= nxt_r;
            col <= nxt_c;
            rph <= nxt_rph;
            cph <= nxt_cph;
        end
    end

    // ---- stage p1: window shift and output flags ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < K; i++)
                for (int j = 0; j < K; j++)
                    win_p1[i][j] <= '0;
        end else if (i_valid) begin
            for (int i = 0; i < K; i++)
                for (int j = 0; j < K; j++)
                    win_p1[i][j] <= (j < K - 1) ? win_p1[i][j+1] : tap[K-1-i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
            eof_p1 <= 1'b0;
        end else begin
            vld_p1 <= i_valid && win_ok;
            eof_p1 <= i_valid && col_wrap && row_wrap;
        end
    end

    assign o_valid = vld_p1;
    assign o_eof   = eof_p1;

    for (genvar i = 0; i < K; i++) begin : g_orow
        for (genvar j = 0; j < K; j++) begin : g_ocol
            assign o_data[(K*K-1-(i*K+j))*DATA_WIDTH +: DATA_WIDTH] = win_p1[i][j];
        end
    end

`ifdef WIN_COORD_EN
    logic [ROW_W-1:0] win_row_p1;
    logic [COL_W-1:0] win_col_p1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_row_p1 <= '0;
            win_col_p1 <= '0;
        end else if (i_valid && win_ok) begin
            win_row_p1 <= pos_r - ROW_K;
            win_col_p1 <= pos_c - COL_K;
        end
    end

    assign o_win_row = win_row_p1;
    assign o_win_col = win_col_p1;
`endif

endmodule

// File: tb/tb_window_gen_kxk.sv
// Self-checking bench for window_gen_kxk: three instances (K3 stride1, K3
// stride2, K5 16x6) driven against a frame-array reference model.
module tb_window_gen_kxk;
    import win_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic a_v, a_s, a_ov, a_oe;
    logic b_v, b_s, b_ov, b_oe;
    logic c_v, c_s, c_ov, c_oe;
    pix_t a_d, b_d, c_d;
    logic [143:0] a_od, b_od;
    logic [399:0] c_od;
`ifdef WIN_COORD_EN
    logic [2:0] a_wr, a_wc, b_wr, b_wc, c_wr;
    logic [3:0] c_wc;
`endif

    window_gen_kxk #(.DATA_WIDTH(16), .K(3), .IMG_WIDTH(8), .IMG_HEIGHT(8), .STRIDE(1)) u_a (
        .clk(clk), .rst_n(rst_n), .i_valid(a_v), .i_sof(a_s), .i_data(a_d),
        .o_valid(a_ov), .o_eof(a_oe),
`ifdef WIN_COORD_EN
        .o_win_row(a_wr), .o_win_col(a_wc),
`endif
        .o_data(a_od));

    window_gen_kxk #(.DATA_WIDTH(16), .K(3), .IMG_WIDTH(8), .IMG_HEIGHT(8), .STRIDE(2)) u_b (
        .clk(clk), .rst_n(rst_n), .i_valid(b_v), .i_sof(b_s), .i_data(b_d),
        .o_valid(b_ov), .o_eof(b_oe),
`ifdef WIN_COORD_EN
        .o_win_row(b_wr), .o_win_col(b_wc),
`endif
        .o_data(b_od));

    window_gen_kxk #(.DATA_WIDTH(16), .K(5), .IMG_WIDTH(16), .IMG_HEIGHT(6), .STRIDE(1)) u_c (
        .clk(clk), .rst_n(rst_n), .i_valid(c_v), .i_sof(c_s), .i_data(c_d),
        .o_valid(c_ov), .o_eof(c_oe),
`ifdef WIN_COORD_EN
        .o_win_row(c_wr), .o_win_col(c_wc),
`endif
        .o_data(c_od));

    int checks = 0;
    int errors = 0;

    // Reference model: the frame as a plain array, position as a linear index.
    pix_t img [3][8][16];
    int   midx [3];

    int           win_cnt, eof_cnt, first_pix, last_pix;
    logic [399:0] first_d;
    bit           log_v [64];
    bit           log_e [64];
    logic [143:0] log_d [64];

    typedef struct {
        int           pix;
        bit           v;
        bit           e;
        logic [143:0] d;
    } vec_t;
    vec_t tbl [5];

    function automatic int cfg_k(input int id); return (id == 2) ? 5 : 3; endfunction
    function automatic int cfg_w(input int id); return (id == 2) ? 16 : 8; endfunction
    function automatic int cfg_h(input int id); return (id == 2) ? 6 : 8; endfunction
    function automatic int cfg_s(input int id); return (id == 1) ? 2 : 1; endfunction

    // 3x3 window of an 8-wide frame whose pixel value is base + r*8 + c.
    function automatic logic [143:0] pack3(input int base, input int r0, input int c0);
        logic [143:0] v;
        v = '0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                v[(8-(i*3+j))*16 +: 16] = 16'(base + (r0 + i) * 8 + (c0 + j));
        return v;
    endfunction

    task automatic chk(input string name, input logic [399:0] act, input logic [399:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic reset_stats();
        win_cnt = 0;
        eof_cnt = 0;
        first_pix = -1;
        last_pix = -1;
        first_d = '0;
    endtask

    task automatic step(input int id, input bit v, input bit s, input pix_t d);
        int k, w, h, st, r, c, pix;
        bit ev, ee;
        logic [399:0] ed, od;
        logic ov, oe;
        k = cfg_k(id); w = cfg_w(id); h = cfg_h(id); st = cfg_s(id);
        a_v = 1'b0; b_v = 1'b0; c_v = 1'b0;
        case (id)
            0: begin a_v = v; a_s = s; a_d = d; end
            1: begin b_v = v; b_s = s; b_d = d; end
            default: begin c_v = v; c_s = s; c_d = d; end
        endcase
        ev = 1'b0; ee = 1'b0; ed = '0; pix = -1; r = 0; c = 0;
        if (v) begin
            if (s) midx[id] = 0;
            pix = midx[id];
            r = pix / w;
            c = pix % w;
            img[id][r][c] = d;
            ev = (r >= k - 1) && (c >= k - 1) && ((r - k + 1) % st == 0) && ((c - k + 1) % st == 0);
            ee = (pix == w * h - 1);
            if (ev)
                for (int i = 0; i < k; i++)
                    for (int j = 0; j < k; j++)
                        ed[(k*k-1-(i*k+j))*16 +: 16] = img[id][r-k+1+i][c-k+1+j];
            midx[id] = (midx[id] + 1) % (w * h);
        end
        @(posedge clk);
        #1;
        od = '0;
        case (id)
            0: begin ov = a_ov; oe = a_oe; od[143:0] = a_od; end
            1: begin ov = b_ov; oe = b_oe; od[143:0] = b_od; end
            default: begin ov = c_ov; oe = c_oe; od = c_od; end
        endcase
        chk($sformatf("dut%0d_valid_pix%0d", id, pix), 400'(ov), 400'(ev));
        chk($sformatf("dut%0d_eof_pix%0d", id, pix), 400'(oe), 400'(ee));
        if (ev) chk($sformatf("dut%0d_data_pix%0d", id, pix), od, ed);
`ifdef WIN_COORD_EN
        if (ev) begin
            case (id)
                0: begin chk("dut0_win_row", 400'(a_wr), 400'(r-k+1)); chk("dut0_win_col", 400'(a_wc), 400'(c-k+1)); end
                1: begin chk("dut1_win_row", 400'(b_wr), 400'(r-k+1)); chk("dut1_win_col", 400'(b_wc), 400'(c-k+1)); end
                default: begin chk("dut2_win_row", 400'(c_wr), 400'(r-k+1)); chk("dut2_win_col", 400'(c_wc), 400'(c-k+1)); end
            endcase
        end
`endif
        if (ov) begin
            win_cnt++;
            if (first_pix < 0) begin
                first_pix = pix;
                first_d = od;
            end
            last_pix = pix;
        end
        if (oe) eof_cnt++;
        if (id == 0 && pix >= 0 && pix < 64) begin
            log_v[pix] = ov;
            log_e[pix] = oe;
            log_d[pix] = od[143:0];
        end
    endtask

    task automatic frame(input int id, input bit sof_first, input int base, input int gap_pct);
        int n;
        n = cfg_w(id) * cfg_h(id);
        for (int p = 0; p < n; p++) begin
            while (int'($urandom_range(99)) < gap_pct)
                step(id, 1'b0, 1'($urandom), 16'($urandom));
            step(id, 1'b1, sof_first && (p == 0), 16'(base + p));
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_a_valid"}, 400'(a_ov), '0);
        chk({tag, "_a_eof"},   400'(a_oe), '0);
        chk({tag, "_a_data"},  400'(a_od), '0);
        chk({tag, "_b_valid"}, 400'(b_ov), '0);
        chk({tag, "_b_data"},  400'(b_od), '0);
        chk({tag, "_c_valid"}, 400'(c_ov), '0);
        chk({tag, "_c_eof"},   400'(c_oe), '0);
        chk({tag, "_c_data"},  c_od, '0);
    endtask

    initial begin
        tbl[0] = '{pix: 18, v: 1'b1, e: 1'b0, d: pack3(0, 0, 0)};
        tbl[1] = '{pix: 17, v: 1'b0, e: 1'b0, d: '0};
        tbl[2] = '{pix: 15, v: 1'b0, e: 1'b0, d: '0};
        tbl[3] = '{pix: 29, v: 1'b1, e: 1'b0, d: pack3(0, 1, 3)};
        tbl[4] = '{pix: 63, v: 1'b1, e: 1'b1, d: pack3(0, 5, 5)};

        rst_n = 1'b0;
        a_v = 0; a_s = 0; a_d = '0;
        b_v = 0; b_s = 0; b_d = '0;
        c_v = 0; c_s = 0; c_d = '0;
        for (int i = 0; i < 3; i++) midx[i] = 0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;

        // Continuous K=3 stride-1 frame
        reset_stats();
        frame(0, 1'b1, 0, 0);
        chk("s1_win_count", 400'(win_cnt), 400'(36));
        chk("s1_eof_count", 400'(eof_cnt), 400'(1));
        chk("s1_first_pix", 400'(first_pix), 400'(18));
        for (int t = 0; t < 5; t++) begin
            chk($sformatf("tbl%0d_valid", t), 400'(log_v[tbl[t].pix]), 400'(tbl[t].v));
            chk($sformatf("tbl%0d_eof", t), 400'(log_e[tbl[t].pix]), 400'(tbl[t].e));
            if (tbl[t].v)
                chk($sformatf("tbl%0d_data", t), 400'(log_d[tbl[t].pix]), 400'(tbl[t].d));
        end
        step(0, 1'b0, 1'b1, 16'h1234);
        chk("idle_hold_data", 400'(a_od), 400'(pack3(0, 5, 5)));

        // Stride 2
        reset_stats();
        frame(1, 1'b1, 0, 0);
        chk("s2_win_count", 400'(win_cnt), 400'(9));
        chk("s2_first_pix", 400'(first_pix), 400'(18));
        chk("s2_last_pix", 400'(last_pix), 400'(54));
        chk("s2_eof_count", 400'(eof_cnt), 400'(1));

        // Random idle gaps
        reset_stats();
        frame(0, 1'b1, 0, 40);
        chk("s3_win_count", 400'(win_cnt), 400'(36));
        chk("s3_first_data", first_d, 400'(pack3(0, 0, 0)));
        chk("s3_eof_count", 400'(eof_cnt), 400'(1));

        // Mid-frame restart at pixel 20
        for (int p = 0; p < 20; p++) step(0, 1'b1, p == 0, 16'(p));
        reset_stats();
        frame(0, 1'b1, 100, 0);
        chk("s4_win_count", 400'(win_cnt), 400'(36));
        chk("s4_first_data", first_d, 400'(pack3(100, 0, 0)));

        // Reset at pixel 30, new frame without sof
        for (int p = 0; p < 30; p++) step(0, 1'b1, p == 0, 16'(p));
        rst_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        a_v = 1'b1; a_s = 1'b0; a_d = 16'h00ff;
        @(posedge clk);
        #1;
        check_all_zero("held_reset");
        a_v = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) midx[i] = 0;
        reset_stats();
        frame(0, 1'b0, 0, 0);
        chk("s5_win_count", 400'(win_cnt), 400'(36));
        chk("s5_first_pix", 400'(first_pix), 400'(18));
        chk("s5_first_data", first_d, 400'(pack3(0, 0, 0)));
        chk("s5_eof_count", 400'(eof_cnt), 400'(1));

        // K=5 on a 16x6 frame
        reset_stats();
        frame(2, 1'b1, 0, 0);
        chk("s6_win_count", 400'(win_cnt), 400'(24));
        chk("s6_first_pix", 400'(first_pix), 400'(68));
        chk("s6_eof_count", 400'(eof_cnt), 400'(1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
